// File: rtl/pipelined_select_stage.sv
// pipelined_select_stage
//
// Registered N:1 operand selector with a valid/ready handshake. An accepted
// selection is resolved immediately into a {data, error} entry and stored in
// a two-deep buffer: a main register that drives the outputs and a skid
// register that absorbs one extra entry while the consumer stalls. Because
// InReady depends only on registered state, the ready path from the consumer
// never reaches the producer combinationally.
//
// Ports:
//   Clock     rising-edge clock
//   ResetN    synchronous active-low reset
//   InputBus  INPUTS packed operands, operand k at [k*WIDTH +: WIDTH]
//   Selector  index of the operand to forward, sampled only on accept
//   InValid   upstream offers a selection this cycle
//   InReady   stage can accept (low while reset is asserted or skid is full)
//   Flush     drop every held entry and any entry offered this cycle
//   Output    data of the entry held in the main register
//   SelError  held entry was selected with Selector >= INPUTS
//   OutValid  Output/SelError carry a valid entry
//   OutReady  downstream consumes the entry this cycle
//
// Parameters: WIDTH (operand width), INPUTS (2..16 selectable operands),
// SEL_W (selector width, 2**SEL_W >= INPUTS), DEFAULT_VALUE (data emitted
// for an out-of-range selector).

module pipelined_select_stage #(
    parameter int              WIDTH         = 32,
    parameter int              INPUTS        = 4,
    parameter int              SEL_W         = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic [WIDTH*INPUTS-1:0] InputBus,
    input  logic [SEL_W-1:0]        Selector,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    Flush,
    output logic [WIDTH-1:0]        Output,
    output logic                    SelError,
    output logic                    OutValid,
    input  logic                    OutReady
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic             main_valid;

    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;

    logic             accept;
    logic             main_load;

    // Out-of-range indices fall through the loop and keep the default entry.
    always_comb begin
        sel_data = DEFAULT_VALUE;
        sel_err  = 1'b1;
        for (int k = 0; k < INPUTS; k++) begin
            if (Selector == SEL_W'(k)) begin
                sel_data = InputBus[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    // ResetN is an input sampled like any other; gating with it keeps the
    // stage closed for the whole reset interval, before the first edge has
    // cleared the skid flag.
    assign InReady   = ResetN && !skid_valid;
    assign accept    = InValid && InReady;
    assign main_load = !main_valid || OutReady;

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (Flush) begin
            // Only the valid flags clear; stale data stays on Output.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_load) begin
            // skid_valid forces InReady low, so a skid move and a new
            // accept can never coincide here.
            if (skid_valid) begin
                main_data  <= skid_data;
                main_err   <= skid_err;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= sel_data;
                main_err   <= sel_err;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= sel_data;
            skid_err   <= sel_err;
            skid_valid <= 1'b1;
        end
    end

    assign Output   = main_data;
    assign SelError = main_err;
    assign OutValid = main_valid;

endmodule

// File: tb/tb_pipelined_select_stage.sv
module tb_pipelined_select_stage;

    logic clk;
    logic rst_n;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // default-parameter instance
    logic [127:0] d_bus;
    logic [1:0]   d_sel;
    logic         d_in_valid, d_in_ready, d_flush;
    logic [31:0]  d_out;
    logic         d_sel_err, d_out_valid, d_out_ready;

    // INPUTS=3 instance for out-of-range selection
    logic [95:0]  o_bus;
    logic [1:0]   o_sel;
    logic         o_in_valid, o_in_ready, o_flush;
    logic [31:0]  o_out;
    logic         o_sel_err, o_out_valid, o_out_ready;

    // WIDTH=8 INPUTS=5 instance for the randomised handshake
    logic [39:0]  r_bus;
    logic [2:0]   r_sel;
    logic         r_in_valid, r_in_ready, r_flush;
    logic [7:0]   r_out;
    logic         r_sel_err, r_out_valid, r_out_ready;

    pipelined_select_stage u_dut (
        .Clock(clk), .ResetN(rst_n), .InputBus(d_bus), .Selector(d_sel),
        .InValid(d_in_valid), .InReady(d_in_ready), .Flush(d_flush),
        .Output(d_out), .SelError(d_sel_err), .OutValid(d_out_valid),
        .OutReady(d_out_ready)
    );

    pipelined_select_stage #(
        .WIDTH(32), .INPUTS(3), .SEL_W(2), .DEFAULT_VALUE(32'hDEADBEEF)
    ) u_oor (
        .Clock(clk), .ResetN(rst_n), .InputBus(o_bus), .Selector(o_sel),
        .InValid(o_in_valid), .InReady(o_in_ready), .Flush(o_flush),
        .Output(o_out), .SelError(o_sel_err), .OutValid(o_out_valid),
        .OutReady(o_out_ready)
    );

    pipelined_select_stage #(
        .WIDTH(8), .INPUTS(5), .SEL_W(3), .DEFAULT_VALUE(8'h5A)
    ) u_rnd (
        .Clock(clk), .ResetN(rst_n), .InputBus(r_bus), .Selector(r_sel),
        .InValid(r_in_valid), .InReady(r_in_ready), .Flush(r_flush),
        .Output(r_out), .SelError(r_sel_err), .OutValid(r_out_valid),
        .OutReady(r_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_bus = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        d_sel = 2'd1; d_in_valid = 1'b1; d_flush = 1'b0; d_out_ready = 1'b0;
        o_bus = '0; o_sel = '0; o_in_valid = 1'b0; o_flush = 1'b0; o_out_ready = 1'b0;
        r_bus = '0; r_sel = '0; r_in_valid = 1'b0; r_flush = 1'b0; r_out_ready = 1'b0;
        repeat (3) tick();
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", d_out_valid); else pass_cnt++;
        total_cnt++; if (d_out !== 32'h0) $display("FAIL reset_output: got %h expected 00000000", d_out); else pass_cnt++;
        total_cnt++; if (d_sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b expected 0", d_sel_err); else pass_cnt++;
        total_cnt++; if (d_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", d_in_ready); else pass_cnt++;
        rst_n = 1'b1;
        d_in_valid = 1'b0;
        tick();
        total_cnt++; if (d_in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", d_in_ready); else pass_cnt++;
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL release_out_valid: got %b expected 0", d_out_valid); else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'hAAAA0000; exp_data[1] = 32'hBBBB0001;
        exp_data[2] = 32'hCCCC0002; exp_data[3] = 32'hDDDD0003;
        d_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_sel = 2'(i);
            d_in_valid = 1'b1;
            tick();
            total_cnt++; if (d_out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", i, d_out_valid); else pass_cnt++;
            total_cnt++; if (d_out !== exp_data[i]) $display("FAIL stream_data[%0d]: got %h expected %h", i, d_out, exp_data[i]); else pass_cnt++;
            total_cnt++; if (d_sel_err !== 1'b0) $display("FAIL stream_err[%0d]: got %b expected 0", i, d_sel_err); else pass_cnt++;
        end
        d_in_valid = 1'b0;
        tick();
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL stream_idle: got %b expected 0", d_out_valid); else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        d_out_ready = 1'b0;
        d_sel = 2'd1; d_in_valid = 1'b1;
        tick();
        total_cnt++; if (d_out !== 32'hBBBB0001) $display("FAIL bp_first: got %h expected bbbb0001", d_out); else pass_cnt++;
        total_cnt++; if (d_in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b expected 1", d_in_ready); else pass_cnt++;
        d_sel = 2'd2;
        tick();
        total_cnt++; if (d_in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", d_in_ready); else pass_cnt++;
        total_cnt++; if (d_out !== 32'hBBBB0001) $display("FAIL bp_hold: got %h expected bbbb0001", d_out); else pass_cnt++;
        // offered while not ready: must be ignored
        d_sel = 2'd3;
        tick();
        total_cnt++; if (d_out !== 32'hBBBB0001) $display("FAIL bp_hold2: got %h expected bbbb0001", d_out); else pass_cnt++;
        total_cnt++; if (d_out_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b expected 1", d_out_valid); else pass_cnt++;
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        tick();
        total_cnt++; if (d_out !== 32'hCCCC0002) $display("FAIL bp_second: got %h expected cccc0002", d_out); else pass_cnt++;
        total_cnt++; if (d_in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", d_in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", d_out_valid); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        o_bus = {32'h33333333, 32'h22222222, 32'h11111111};
        o_out_ready = 1'b1;
        o_sel = 2'd3; o_in_valid = 1'b1;
        tick();
        total_cnt++; if (o_out !== 32'hDEADBEEF) $display("FAIL oor_data: got %h expected deadbeef", o_out); else pass_cnt++;
        total_cnt++; if (o_sel_err !== 1'b1) $display("FAIL oor_err: got %b expected 1", o_sel_err); else pass_cnt++;
        total_cnt++; if (o_out_valid !== 1'b1) $display("FAIL oor_valid: got %b expected 1", o_out_valid); else pass_cnt++;
        o_sel = 2'd0;
        tick();
        total_cnt++; if (o_out !== 32'h11111111) $display("FAIL oor_next_data: got %h expected 11111111", o_out); else pass_cnt++;
        total_cnt++; if (o_sel_err !== 1'b0) $display("FAIL oor_next_err: got %b expected 0", o_sel_err); else pass_cnt++;
        o_sel = 2'd2;
        tick();
        total_cnt++; if (o_out !== 32'h33333333) $display("FAIL oor_last_data: got %h expected 33333333", o_out); else pass_cnt++;
        total_cnt++; if (o_sel_err !== 1'b0) $display("FAIL oor_last_err: got %b expected 0", o_sel_err); else pass_cnt++;
        o_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        d_out_ready = 1'b0;
        d_sel = 2'd0; d_in_valid = 1'b1;
        tick();
        d_sel = 2'd1;
        tick();
        total_cnt++; if (d_in_ready !== 1'b0) $display("FAIL flush_full: got %b expected 0", d_in_ready); else pass_cnt++;
        d_flush = 1'b1; d_sel = 2'd2;
        tick();
        d_flush = 1'b0; d_in_valid = 1'b0;
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", d_out_valid); else pass_cnt++;
        total_cnt++; if (d_in_ready !== 1'b1) $display("FAIL flush_ready: got %b expected 1", d_in_ready); else pass_cnt++;
        total_cnt++; if (d_out !== 32'hAAAA0000) $display("FAIL flush_data_kept: got %h expected aaaa0000", d_out); else pass_cnt++;
        d_out_ready = 1'b1;
        tick();
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL flush_no_skid: got %b expected 0", d_out_valid); else pass_cnt++;
        // flush while the stage is ready: the offered entry is dropped
        d_flush = 1'b1; d_in_valid = 1'b1; d_sel = 2'd3;
        tick();
        d_flush = 1'b0; d_in_valid = 1'b0;
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL flush_offer: got %b expected 0", d_out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (d_out_valid !== 1'b0) $display("FAIL flush_offer_late: got %b expected 0", d_out_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [8:0] model_q[$];
        logic [8:0] exp_e;
        logic [8:0] got_e;
        int         bad_cycles;
        bad_cycles = 0;
        for (int cyc = 0; cyc < 1006; cyc++) begin
            if (cyc < 1000) begin
                r_in_valid  = 1'($urandom_range(0, 1));
                r_out_ready = 1'($urandom_range(0, 1));
                r_sel       = 3'($urandom_range(0, 7));
                r_bus       = 40'({$urandom(), $urandom()});
            end else begin
                r_in_valid  = 1'b0;
                r_out_ready = 1'b1;
            end
            #1;
            total_cnt++;
            if (r_out_valid !== (model_q.size() != 0)) begin
                $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, r_out_valid, model_q.size() != 0);
                bad_cycles++;
            end else pass_cnt++;
            total_cnt++;
            if (r_in_ready !== (model_q.size() < 2)) begin
                $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, r_in_ready, model_q.size() < 2);
                bad_cycles++;
            end else pass_cnt++;
            if (r_out_valid === 1'b1 && r_out_ready) begin
                got_e = {r_sel_err, r_out};
                exp_e = (model_q.size() != 0) ? model_q.pop_front() : 9'h1FF;
                total_cnt++;
                if (got_e !== exp_e) begin
                    $display("FAIL rnd_data cyc %0d: got %h expected %h", cyc, got_e, exp_e);
                    bad_cycles++;
                end else pass_cnt++;
            end
            if (r_in_valid && r_in_ready === 1'b1) begin
                if (r_sel < 3'd5)
                    model_q.push_back({1'b0, r_bus[r_sel*8 +: 8]});
                else
                    model_q.push_back({1'b1, 8'h5A});
            end
            if (bad_cycles > 20) begin
                $display("FAIL rnd_abort: too many errors at cyc %0d", cyc);
                break;
            end
            tick();
        end
        total_cnt++; if (model_q.size() != 0) $display("FAIL rnd_drain: got %0d entries left expected 0", model_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_out_of_range();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipelined_select_stage.md
Name: pipelined_select_stage

Overview:
- Parametrised successor of the processor's combinational 4:1 datapath selector.
- Registered N:1 selection of WIDTH-bit operands with valid/ready handshake, 2-entry skid buffer for full throughput under back-pressure, synchronous flush, and out-of-range selector detection.
- Sits between operand-source stages (register file, ALU result, memory read data, immediate) and the consumer stage, for forwarding and write-back selection in pipelined cores.

Parameters:
- WIDTH, 32, bit width of each input and of Output.
- INPUTS, 4, number of selectable inputs (2..16).
- SEL_W, 2, Selector width; must satisfy 2**SEL_W >= INPUTS.
- DEFAULT_VALUE, 0, WIDTH-bit value emitted when Selector >= INPUTS.

Ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  synchronous active-low reset.
- InputBus  in  WIDTH*INPUTS  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- Selector  in  SEL_W  index of the input to forward.
- InValid  in  1  upstream presents a selection this cycle.
- InReady  out  1  stage can accept; transfer happens when InValid && InReady.
- Flush  in  1  discard all held entries.
- Output  out  WIDTH  selected data.
- SelError  out  1  held entry was selected with Selector >= INPUTS.
- OutValid  out  1  Output/SelError valid.
- OutReady  in  1  downstream accepts; transfer happens when OutValid && OutReady.

Behaviour:
- Reset (ResetN low at a rising edge): OutValid=0, Output=0, SelError=0, skid entry invalid with data 0. InReady=0 while ResetN is low; InReady=1 in the first cycle after release.
- Selection is evaluated on input accept. Data = input[Selector] if Selector < INPUTS; otherwise DEFAULT_VALUE with error bit 1. Data and error bit are captured together as one entry.
- Storage: main register (drives Output, SelError, OutValid) and one skid register.
- InReady = !skid_valid (registered state only; no combinational path from OutReady).
- Latency: 1 cycle. An entry accepted at edge N is visible on Output at edge N when main was empty or draining.
- Per rising edge, with ResetN=1 and Flush=0:
  - main empty, or main draining (OutReady=1): main loads skid if skid is valid, else the accepted input, else becomes invalid; a skid entry moved to main empties the skid.
  - main full and stalled (OutReady=0), input accepted: entry goes to skid; InReady drops next cycle.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- Output and SelError hold stable while OutValid=1 and OutReady=0.
- Flush=1 at an edge: main and skid invalid, OutValid=0, InReady=1 next cycle. Any input offered in the same cycle is discarded. Flush overrides accept and drain. Output data is not cleared; only the valid flags are.
- ResetN low overrides Flush.
- Reset mid-operation discards both entries regardless of handshake state.
- Throughput: 1 entry per cycle while OutReady=1 continuously.
- Max occupancy is 2. After OutReady rises, InReady re-asserts the cycle after the skid drains.
- Selector is sampled only on accept; changes while InReady=0 have no effect.

Test Plan:
- Reset/idle: hold ResetN=0 for 3 cycles with InValid=1 -> OutValid=0, Output=0, SelError=0, InReady=0. Release -> InReady=1, nothing accepted during reset.
- Streaming select: InputBus = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, Selector 0,1,2,3 on consecutive cycles, OutReady=1 -> Output 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on 4 consecutive cycles, each 1 cycle after accept; SelError=0.
- Back-pressure: OutReady=0 while sending Selector 1 then 2 -> first entry in main, second in skid, InReady=0, Output held at 0xBBBB0001. Raise OutReady -> 0xBBBB0001 then 0xCCCC0002, InReady=1 one cycle after the skid drains, no loss.
- Out-of-range: INPUTS=3, SEL_W=2, DEFAULT_VALUE=0xDEADBEEF, Selector=3 -> Output 0xDEADBEEF, SelError=1 with OutValid=1. Next entry, Selector=0 -> SelError=0.
- Flush with full stage: main and skid full, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, flushed and offered entries never appear on Output.
- Randomised handshake (1000 cycles, random InValid/OutReady/Selector, WIDTH=8, INPUTS=5) -> output sequence matches a reference queue model exactly.
